// File: rtl/nn_sched_pkg.sv
// Shared encodings for the inference scheduler: FSM states, class width default
// and the class value reported on a network timeout.
package nn_sched_pkg;

    localparam int CLASS_SIZE_DEF = 4;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_IDLE = 2'd0;
    localparam sched_state_t ST_LOAD = 2'd1;
    localparam sched_state_t ST_WAIT = 2'd2;
    localparam sched_state_t ST_RESP = 2'd3;

    // Sliced down to CLASS_SIZE by the user; classes wider than 32 bits are not supported.
    localparam logic [31:0] ERR_CLASS_ALL = 32'hFFFF_FFFF;

endpackage

// File: rtl/nn_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr_i, wrapping,
// and reports it both one-hot and as an index.
module nn_rr_arbiter
    import nn_sched_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int  j;
        logic found;
        j       = 0;
        found   = 1'b0;
        grant_o = '0;
        idx_o   = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!found && req_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = j[IW-1:0];
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/nn_infer_scheduler.sv
// Serves image requesters round-robin into a single inference network and returns
// one result per job. Define NN_SCHED_TIMEOUT_EN to bound the time spent waiting on the network.
//
// state | meaning
// IDLE  | no job; grant the next requester when any req_valid is high
// LOAD  | image registered on nn_input, nn_load strobed for one cycle
// WAIT  | waiting for nn_done (or the timeout, when enabled)
// RESP  | result held on rsp_* until rsp_ready
module nn_infer_scheduler
    import nn_sched_pkg::*;
#(
    parameter int NUM_REQ            = 2,
    parameter int LAYER_1_INPUT_SIZE = 256,
    parameter int CLASS_SIZE         = CLASS_SIZE_DEF,
    parameter int TIMEOUT_CYCLES     = 511
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ*LAYER_1_INPUT_SIZE-1:0] req_image,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic [LAYER_1_INPUT_SIZE-1:0]         nn_input,
    output logic                                  nn_load,
    input  logic                                  nn_done,
    input  logic [CLASS_SIZE-1:0]                 nn_max,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]            rsp_id,
    output logic [CLASS_SIZE-1:0]                 rsp_class,
    output logic                                  rsp_error,
    output logic                                  busy
);

    localparam int IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("nn_infer_scheduler: unsupported parameter set");
    end

    sched_state_t                  state_q, state_d;
    logic [IDW-1:0]                ptr_q, ptr_d;
    logic [LAYER_1_INPUT_SIZE-1:0] nn_input_q, nn_input_d;
    logic [IDW-1:0]                rsp_id_q, rsp_id_d;
    logic [CLASS_SIZE-1:0]         rsp_class_q, rsp_class_d;

    logic [NUM_REQ-1:0] gnt_vec;
    logic [IDW-1:0]     gnt_idx;
    logic               gnt_any;
    logic               timeout;

    nn_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (gnt_vec),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

`ifdef NN_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            rsp_error_q, rsp_error_d;

    // Loaded in LOAD so that WAIT lasts exactly TIMEOUT_CYCLES cycles before expiring.
    always_comb begin
        to_cnt_d    = to_cnt_q;
        rsp_error_d = rsp_error_q;
        if (state_q == ST_LOAD) begin
            to_cnt_d = TO_W'(TIMEOUT_CYCLES - 1);
        end else if (state_q == ST_WAIT && to_cnt_q != '0) begin
            to_cnt_d = to_cnt_q - TO_W'(1);
        end
        if (state_q == ST_WAIT && (nn_done || timeout)) begin
            rsp_error_d = !nn_done;
        end
    end

    assign timeout   = (state_q == ST_WAIT) && (to_cnt_q == '0);
    assign rsp_error = rsp_error_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q    <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            to_cnt_q    <= to_cnt_d;
            rsp_error_q <= rsp_error_d;
        end
    end
`else
    assign timeout   = 1'b0;
    assign rsp_error = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        nn_input_d  = nn_input_q;
        rsp_id_d    = rsp_id_q;
        rsp_class_d = rsp_class_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    nn_input_d = req_image[int'(gnt_idx)*LAYER_1_INPUT_SIZE +: LAYER_1_INPUT_SIZE];
                    rsp_id_d   = gnt_idx;
                    ptr_d      = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_WAIT;
            ST_WAIT: begin
                // nn_done takes precedence over an expiry in the same cycle.
                if (nn_done) begin
                    rsp_class_d = nn_max;
                    state_d     = ST_RESP;
                end else if (timeout) begin
                    rsp_class_d = ERR_CLASS_ALL[CLASS_SIZE-1:0];
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            nn_input_q  <= '0;
            rsp_id_q    <= '0;
            rsp_class_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            nn_input_q  <= nn_input_d;
            rsp_id_q    <= rsp_id_d;
            rsp_class_q <= rsp_class_d;
        end
    end

    // The accept pulse is combinational, so it is gated by reset to stay low while reset is held.
    assign req_ready = (reset && state_q == ST_IDLE) ? gnt_vec : '0;
    assign nn_input  = nn_input_q;
    assign nn_load   = (state_q == ST_LOAD);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_class = rsp_class_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nn_infer_scheduler.sv
// Self-checking bench for nn_infer_scheduler: table-driven jobs, hand-written corner
// sequences and a randomized phase checked against a transaction-level model.
module tb_nn_infer_scheduler;

    localparam int N  = 4;
    localparam int W  = 256;
    localparam int C  = 4;
    localparam int TO = 511;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_image;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   nn_input;
    logic           nn_load;
    logic           nn_done;
    logic [C-1:0]   nn_max;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [C-1:0]   rsp_class;
    logic           rsp_error;
    logic           busy;

    logic [W-1:0] img [N];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_image = '0;
        for (int i = 0; i < N; i++) req_image[i*W +: W] = img[i];
    end

    nn_infer_scheduler #(
        .NUM_REQ(N), .LAYER_1_INPUT_SIZE(W), .CLASS_SIZE(C), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_image(req_image),
        .req_ready(req_ready), .nn_input(nn_input), .nn_load(nn_load), .nn_done(nn_done),
        .nn_max(nn_max), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_class(rsp_class), .rsp_error(rsp_error), .busy(busy)
    );

    task automatic chki(input string name, input int act, input int exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic chk_img(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [W-1:0] rand_img();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Round-robin reference: first pending requester strictly after the last one served.
    function automatic int rr_pick(input logic [N-1:0] p, input int last_g);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last_g + k) % N;
            if (p[j]) return j;
        end
        return -1;
    endfunction

    task automatic reset_dut();
        reset     = 1'b0;
        req_valid = '0;
        nn_done   = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    // One complete job: grant, load, (dly) wait cycles, done, (rdly) backpressure cycles, accept.
    task automatic run_job(input logic [N-1:0] mask, input int exp_idx, input int dly,
                           input logic [C-1:0] cls, input int rdly, input logic [N-1:0] bg,
                           input logic spur);
        @(negedge clk);
        for (int i = 0; i < N; i++) img[i] = rand_img();
        req_valid = mask;
        nn_done   = spur;
        rsp_ready = 1'b0;
        #1;
        chki("grant", int'(req_ready), 1 << exp_idx);
        chki("grant_busy", int'(busy), 0);
        @(negedge clk);
        req_valid = bg;
        #1;
        chki("load_strobe", int'(nn_load), 1);
        chk_img("load_image", nn_input, img[exp_idx]);
        chki("load_no_ready", int'(req_ready), 0);
        chki("load_no_rsp", int'(rsp_valid), 0);
        @(negedge clk);
        nn_done = 1'b0;
        for (int k = 0; k < dly; k++) begin
            #1;
            chki("wait_no_rsp", int'(rsp_valid), 0);
            chki("wait_no_load", int'(nn_load), 0);
            chki("wait_busy", int'(busy), 1);
            @(negedge clk);
        end
        nn_done = 1'b1;
        nn_max  = cls;
        #1;
        chki("done_cycle_no_rsp", int'(rsp_valid), 0);
        @(negedge clk);
        nn_done   = 1'b0;
        nn_max    = ~cls;
        rsp_ready = (rdly == 0);
        #1;
        chki("rsp_valid", int'(rsp_valid), 1);
        chki("rsp_id", int'(rsp_id), exp_idx);
        chki("rsp_class", int'(rsp_class), int'(cls));
        chki("rsp_error", int'(rsp_error), 0);
        for (int k = 0; k < rdly; k++) begin
            @(negedge clk);
            rsp_ready = (k == rdly - 1);
            nn_max    = C'($urandom);
            #1;
            chki("hold_valid", int'(rsp_valid), 1);
            chki("hold_id", int'(rsp_id), exp_idx);
            chki("hold_class", int'(rsp_class), int'(cls));
            chki("hold_no_ready", int'(req_ready), 0);
            chki("hold_no_load", int'(nn_load), 0);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = '0;
        #1;
        chki("after_rsp_valid", int'(rsp_valid), 0);
        chki("after_rsp_busy", int'(busy), 0);
    endtask

    typedef struct {
        logic [N-1:0] mask;
        int           exp_idx;
        int           dly;
        logic [C-1:0] cls;
        int           rdly;
        logic [N-1:0] bg;
        logic         spur;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int g_idx [$];
        int g_cyc [$];
        logic [N-1:0] pend;
        int last_g, net_cnt, exp_id, g, exp_rdy;
        bit job, load_due, resp_due, done_now;
        logic [W-1:0] exp_img;
        logic [C-1:0] exp_cls;

        // Rows follow each other from reset, so each expected grant accounts for the previous ones.
        tbl[0] = '{4'b0001, 0, 1, 4'd4,  0,  4'b0000, 1'b0};
        tbl[1] = '{4'b0011, 1, 0, 4'd9,  0,  4'b0000, 1'b0};
        tbl[2] = '{4'b0011, 0, 2, 4'd3,  1,  4'b0000, 1'b0};
        tbl[3] = '{4'b0011, 1, 0, 4'd12, 10, 4'b1111, 1'b0};
        tbl[4] = '{4'b1001, 3, 1, 4'd7,  0,  4'b0000, 1'b1};
        tbl[5] = '{4'b1110, 1, 3, 4'd0,  2,  4'b0000, 1'b0};
        tbl[6] = '{4'b0100, 2, 0, 4'd15, 0,  4'b0000, 1'b0};
        tbl[7] = '{4'b1111, 3, 1, 4'd5,  0,  4'b0000, 1'b0};
        tbl[8] = '{4'b1111, 0, 0, 4'd10, 0,  4'b0000, 1'b0};
        tbl[9] = '{4'b1000, 3, 4, 4'd1,  3,  4'b0000, 1'b0};

        for (int i = 0; i < N; i++) img[i] = rand_img();
        nn_max    = '0;
        reset     = 1'b0;
        req_valid = '1;
        nn_done   = 1'b1;
        rsp_ready = 1'b1;
        #2;
        chki("reset_req_ready", int'(req_ready), 0);
        chk_img("reset_nn_input", nn_input, '0);
        chki("reset_nn_load", int'(nn_load), 0);
        chki("reset_rsp_valid", int'(rsp_valid), 0);
        chki("reset_rsp_id", int'(rsp_id), 0);
        chki("reset_rsp_class", int'(rsp_class), 0);
        chki("reset_rsp_error", int'(rsp_error), 0);
        chki("reset_busy", int'(busy), 0);
        reset_dut();

        // Spurious done while idle.
        @(negedge clk);
        nn_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chki("spur_idle_busy", int'(busy), 0);
            chki("spur_idle_rsp", int'(rsp_valid), 0);
        end
        nn_done = 1'b0;

        for (int r = 0; r < 10; r++)
            run_job(tbl[r].mask, tbl[r].exp_idx, tbl[r].dly, tbl[r].cls, tbl[r].rdly, tbl[r].bg, tbl[r].spur);

        // Contention from reset: both held, done and ready always high -> 0,1,0,1 every 4 cycles.
        reset_dut();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_valid = 4'b0011;
                rsp_ready = 1'b1;
                nn_done   = 1'b1;
                nn_max    = 4'd3;
            end
            #1;
            if (req_ready != '0) begin
                chki("contend_onehot", int'($onehot(req_ready)), 1);
                for (int i = 0; i < N; i++) if (req_ready[i]) g_idx.push_back(i);
                g_cyc.push_back(c);
            end
        end
        @(negedge clk);
        req_valid = '0;
        nn_done   = 1'b0;
        rsp_ready = 1'b0;
        chki("contend_grants", g_idx.size(), 4);
        for (int k = 0; k < g_idx.size(); k++) begin
            chki("contend_order", g_idx[k], k % 2);
            chki("contend_interval", g_cyc[k], 4 * k);
        end

        // Reset during WAIT abandons the job.
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        chki("pre_reset_grant", int'(req_ready), 4);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #2;
        reset     = 1'b0;
        req_valid = '1;
        #1;
        chki("async_req_ready", int'(req_ready), 0);
        chk_img("async_nn_input", nn_input, '0);
        chki("async_nn_load", int'(nn_load), 0);
        chki("async_rsp_valid", int'(rsp_valid), 0);
        chki("async_rsp_id", int'(rsp_id), 0);
        chki("async_rsp_class", int'(rsp_class), 0);
        chki("async_rsp_error", int'(rsp_error), 0);
        chki("async_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        nn_done   = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) begin
            #1;
            chki("post_reset_no_rsp", int'(rsp_valid), 0);
            chki("post_reset_no_load", int'(nn_load), 0);
            chki("post_reset_idle", int'(busy), 0);
            @(negedge clk);
        end
        nn_done   = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '1;
        #1;
        chki("post_reset_grant", int'(req_ready), 1);
        @(negedge clk);
        req_valid = '0;
        #1;
        chki("post_reset_load", int'(nn_load), 1);
        chk_img("post_reset_image", nn_input, img[0]);

`ifdef NN_SCHED_TIMEOUT_EN
        begin
            int waited;
            bit got;
            waited = 0;
            got    = 1'b0;
            for (int c = 0; c < 2000 && !got; c++) begin
                @(negedge clk);
                #1;
                if (rsp_valid) got = 1'b1;
                else waited++;
            end
            chki("timeout_seen", int'(got), 1);
            chki("timeout_wait_cycles", waited, TO);
            chki("timeout_error", int'(rsp_error), 1);
            chki("timeout_class", int'(rsp_class), 15);
            chki("timeout_id", int'(rsp_id), 0);
            @(negedge clk);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            #1;
            chki("timeout_release", int'(busy), 0);
        end
`else
        begin
            int bad;
            bad = 0;
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                #1;
                if (rsp_valid || !busy || rsp_error) bad++;
            end
            chki("no_timeout_wait", bad, 0);
            reset_dut();
        end
`endif

        // nn_done arriving in the last permitted WAIT cycle.
        run_job(4'b0010, 1, TO - 1, 4'd6, 0, 4'b0000, 1'b0);

        // Randomized traffic against a transaction-level model.
        reset_dut();
        pend     = '0;
        last_g   = N - 1;
        net_cnt  = -1;
        job      = 1'b0;
        load_due = 1'b0;
        resp_due = 1'b0;
        exp_img  = '0;
        exp_cls  = '0;
        exp_id   = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(3) == 0) begin
                    pend[i] = 1'b1;
                    img[i]  = rand_img();
                end
            end
            req_valid = pend;
            done_now  = 1'b0;
            nn_done   = 1'b0;
            nn_max    = C'($urandom);
            if (net_cnt == 0) begin
                nn_done  = 1'b1;
                done_now = 1'b1;
                exp_cls  = nn_max;
                net_cnt  = -1;
            end else if (net_cnt > 0) begin
                net_cnt--;
            end else if (!job && $urandom_range(3) == 0) begin
                nn_done = 1'b1;
            end
            rsp_ready = 1'($urandom_range(1));
            #1;
            g       = (!job) ? rr_pick(pend, last_g) : -1;
            exp_rdy = (g >= 0) ? (1 << g) : 0;
            chki("rnd_grant", int'(req_ready), exp_rdy);
            chki("rnd_load", int'(nn_load), int'(load_due));
            chk_img("rnd_image", nn_input, exp_img);
            chki("rnd_rsp_valid", int'(rsp_valid), int'(resp_due));
            chki("rnd_busy", int'(busy), int'(job));
            if (resp_due) begin
                chki("rnd_rsp_id", int'(rsp_id), exp_id);
                chki("rnd_rsp_class", int'(rsp_class), int'(exp_cls));
                chki("rnd_rsp_error", int'(rsp_error), 0);
            end
            if (load_due) begin
                load_due = 1'b0;
                net_cnt  = int'($urandom_range(4));
            end
            if (resp_due && rsp_ready) begin
                resp_due = 1'b0;
                job      = 1'b0;
            end
            if (done_now) resp_due = 1'b1;
            if (g >= 0) begin
                job      = 1'b1;
                load_due = 1'b1;
                exp_id   = g;
                exp_img  = img[g];
                pend[g]  = 1'b0;
                last_g   = g;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
